uart_freq_cmd_rx: RTL and testbench

- UART receiver and command parser directly upstream of the PWM sine generator.
- Oversamples `uart_rxd` and assembles 8N1 bytes.
- Parses 3-byte frames (header, freq high byte, freq low byte) into a frequency tuning word.
- The sine phase accumulator consumes that word on a one-cycle `freq_valid` strobe.

---
 rtl/uart_freq_cmd_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_freq_cmd_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_freq_cmd_rx.sv
// Purpose: oversampled 8N1 UART receiver plus a 3-byte frame parser (HDR, hi, lo) driving a 16-bit tuning word.
// Latency: 2-cycle input sync; rx_strobe lands one cycle after the mid-stop sample; freq_valid one cycle after the last rx_strobe.
// Backpressure: none; the consumer must accept the one-cycle freq_valid / rx_strobe / frame_err pulses.
// Ports: clk, rst_n (async active-low), uart_rxd (async serial in) -> freq_word, freq_valid, rx_byte, rx_strobe, frame_err, busy.
// Build option: define UART_PARITY_EN to add an even-parity bit (8E1) between data and stop.
module uart_freq_cmd_rx #(
    parameter int          CLK_HZ       = 50000000,
    parameter int          BAUD         = 115200,
    parameter int          OVERSAMPLE   = 16,
    parameter logic [7:0]  HDR          = 8'hA5,
    parameter logic [15:0] FREQ_RESET   = 16'h0100,
    parameter int          IDLE_TIMEOUT = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    output logic [15:0] freq_word,
    output logic        freq_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        frame_err,
    output logic        busy
);
    localparam int DIV_RAW   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int TO_CYCLES = IDLE_TIMEOUT * OVERSAMPLE * DIV;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HI
    } rx_state_t;

    typedef enum logic [1:0] {P_HDR, P_HI, P_LO} p_state_t;

    rx_state_t        rx_state, rx_nxt;
    p_state_t         p_state, p_nxt;
    logic             sync1, sync2;
    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       hi_byte;
    logic [TO_W-1:0]  to_cnt;
    logic             tick, bit_sample, restart, realign;
    logic             strobe_nxt, err_nxt;
    logic             timeout, abort, load_hi, load_freq;
    logic             par_bad;

    assign busy       = (rx_state != S_IDLE);
    assign tick       = busy && (div_cnt == DIV_W'(DIV - 1));
    assign bit_sample = tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));

    // RX next-state / pulse decode
    always_comb begin
        rx_nxt     = rx_state;
        strobe_nxt = 1'b0;
        err_nxt    = 1'b0;
        restart    = 1'b0;
        realign    = 1'b0;
        case (rx_state)
            S_IDLE: if (!sync2) begin
                rx_nxt  = S_START;
                restart = 1'b1;
            end
            S_START: if (tick && (tick_cnt == OS_W'(OVERSAMPLE / 2 - 1))) begin
                // Mid-start sample: a high here means the falling edge was a glitch.
                realign = 1'b1;
                rx_nxt  = sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (bit_sample && (bit_cnt == 3'd7)) begin
`ifdef UART_PARITY_EN
                rx_nxt = S_PARITY;
`else
                rx_nxt = S_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (bit_sample) rx_nxt = S_STOP;
`endif
            S_STOP: if (bit_sample) begin
                strobe_nxt = sync2 && !par_bad;
                err_nxt    = !sync2 || par_bad;
                // A low stop bit may be a break; wait for the line to go high before re-arming.
                rx_nxt     = sync2 ? S_IDLE : S_WAIT_HI;
            end
            S_WAIT_HI: if (sync2) rx_nxt = S_IDLE;
            default: rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rx_state  <= S_IDLE;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= uart_rxd;
            sync2     <= sync1;
            rx_state  <= rx_nxt;
            rx_strobe <= strobe_nxt;
            frame_err <= err_nxt;

            if (restart || !busy || tick) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 1'b1;

            // After the mid-start sample the tick count restarts so later samples fall mid-bit.
            if (restart || realign)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= (tick_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;

            if (restart)
                bit_cnt <= '0;
            else if (rx_state == S_DATA && bit_sample) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {sync2, shreg[7:1]};
            end

            if (strobe_nxt) rx_byte <= shreg;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_bad <= 1'b0;
        else if (restart)
            par_bad <= 1'b0;
        else if (rx_state == S_PARITY && bit_sample)
            par_bad <= (^shreg) ^ sync2;
    end
`else
    assign par_bad = 1'b0;
`endif

    // Parser: timeout counts RX-idle cycles accumulated since the last good byte.
    assign timeout = (p_state != P_HDR) && (to_cnt == TO_W'(TO_CYCLES));
    assign abort   = frame_err || timeout;

    always_comb begin
        p_nxt     = p_state;
        load_hi   = 1'b0;
        load_freq = 1'b0;
        if (abort)
            p_nxt = P_HDR;
        else if (rx_strobe) begin
            case (p_state)
                P_HDR: if (rx_byte == HDR) p_nxt = P_HI;
                P_HI: begin
                    load_hi = 1'b1;
                    p_nxt   = P_LO;
                end
                P_LO: begin
                    load_freq = 1'b1;
                    p_nxt     = P_HDR;
                end
                default: p_nxt = P_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state    <= P_HDR;
            hi_byte    <= '0;
            freq_word  <= FREQ_RESET;
            freq_valid <= 1'b0;
            to_cnt     <= '0;
        end else begin
            p_state    <= p_nxt;
            freq_valid <= load_freq;
            if (load_hi)   hi_byte   <= rx_byte;
            if (load_freq) freq_word <= {hi_byte, rx_byte};
            if (rx_strobe || p_state == P_HDR)
                to_cnt <= '0;
            else if (rx_state == S_IDLE && !timeout)
                to_cnt <= to_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_freq_cmd_rx.sv
module tb_uart_freq_cmd_rx;
    localparam int BIT_CLKS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rxd;
    logic [15:0] freq_word;
    logic        freq_valid;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        frame_err;
    logic        busy;

    uart_freq_cmd_rx #(
        .CLK_HZ(1000000), .BAUD(62500), .OVERSAMPLE(16),
        .HDR(8'hA5), .FREQ_RESET(16'h0100), .IDLE_TIMEOUT(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd),
        .freq_word(freq_word), .freq_valid(freq_valid),
        .rx_byte(rx_byte), .rx_strobe(rx_strobe),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_freq[$];
    int          exp_errs = 0;
    int          n_strobe = 0, n_valid = 0, n_err = 0;
    logic        busy_seen = 1'b0;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_seen = 1'b1;
            if (rx_strobe) begin
                n_strobe++;
                if (exp_bytes.size() == 0) check("unexpected_rx_strobe", 1'b0, {24'h0, rx_byte}, 32'h0);
                else begin
                    logic [7:0] e;
                    e = exp_bytes.pop_front();
                    check("rx_byte", rx_byte == e, {24'h0, rx_byte}, {24'h0, e});
                end
            end
            if (freq_valid) begin
                n_valid++;
                if (exp_freq.size() == 0) check("unexpected_freq_valid", 1'b0, {16'h0, freq_word}, 32'h0);
                else begin
                    logic [15:0] f;
                    f = exp_freq.pop_front();
                    check("freq_word_on_valid", freq_word == f, {16'h0, freq_word}, {16'h0, f});
                end
            end
            if (frame_err) begin
                n_err++;
                check("frame_err_expected", exp_errs > 0, 32'(exp_errs), 32'd1);
                if (exp_errs > 0) exp_errs--;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_period(input logic b);
        uart_rxd = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic pb;
        pb = (^d) ^ par_flip;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
`ifdef UART_PARITY_EN
        bit_period(pb);
`endif
        bit_period(stop_b);
        uart_rxd = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_bytes.push_back(d);
        send_byte(d, 1'b1, 1'b0);
    endtask

    task automatic drained(input string name);
        check({name, "_bytes_drained"}, exp_bytes.size() == 0, 32'(exp_bytes.size()), 32'd0);
        check({name, "_freq_drained"}, exp_freq.size() == 0, 32'(exp_freq.size()), 32'd0);
        check({name, "_err_drained"}, exp_errs == 0, 32'(exp_errs), 32'd0);
    endtask

    initial begin
        int v0, e0, s0;
        uart_rxd = 1'b1;
        rst_n    = 1'b0;
        idle(5);
        check("rst_freq_word", freq_word == 16'h0100, {16'h0, freq_word}, 32'h0100);
        check("rst_rx_byte", rx_byte == 8'h00, {24'h0, rx_byte}, 32'h0);
        check("rst_strobes", {freq_valid, rx_strobe, frame_err} == 3'b000, {29'h0, freq_valid, rx_strobe, frame_err}, 32'h0);
        check("rst_busy", busy == 1'b0, {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        idle(1000);
        check("idle_no_events", (n_strobe + n_valid + n_err) == 0, 32'(n_strobe + n_valid + n_err), 32'd0);
        check("idle_not_busy", busy_seen == 1'b0, {31'h0, busy_seen}, 32'h0);

        // Nominal frame
        v0 = n_valid;
        exp_freq.push_back(16'h1234);
        send_good(8'hA5); send_good(8'h12); send_good(8'h34);
        idle(40);
        check("nominal_freq_word", freq_word == 16'h1234, {16'h0, freq_word}, 32'h1234);
        check("nominal_one_valid", n_valid - v0 == 1, 32'(n_valid - v0), 32'd1);
        drained("nominal");

        // Bad header byte ignored
        v0 = n_valid;
        exp_freq.push_back(16'h0007);
        send_good(8'h5A); send_good(8'hA5); send_good(8'h00); send_good(8'h07);
        idle(40);
        check("badhdr_freq_word", freq_word == 16'h0007, {16'h0, freq_word}, 32'h0007);
        check("badhdr_one_valid", n_valid - v0 == 1, 32'(n_valid - v0), 32'd1);
        drained("badhdr");

        // Framing error aborts the frame
        v0 = n_valid; e0 = n_err;
        send_good(8'hA5);
        exp_errs++;
        send_byte(8'h12, 1'b0, 1'b0);
        idle(40);
        check("ferr_pulse", n_err - e0 == 1, 32'(n_err - e0), 32'd1);
        check("ferr_no_valid", n_valid - v0 == 0, 32'(n_valid - v0), 32'd0);
        check("ferr_freq_kept", freq_word == 16'h0007, {16'h0, freq_word}, 32'h0007);
        exp_freq.push_back(16'hABCD);
        send_good(8'hA5); send_good(8'hAB); send_good(8'hCD);
        idle(40);
        check("ferr_recover_freq", freq_word == 16'hABCD, {16'h0, freq_word}, 32'hABCD);
        drained("ferr");

        // 3-cycle glitch
        s0 = n_strobe; e0 = n_err;
        busy_seen = 1'b0;
        uart_rxd = 1'b0; idle(3); uart_rxd = 1'b1;
        idle(20);
        check("glitch_started", busy_seen == 1'b1, {31'h0, busy_seen}, 32'h1);
        check("glitch_busy_dropped", busy == 1'b0, {31'h0, busy}, 32'h0);
        check("glitch_no_events", (n_strobe - s0) + (n_err - e0) == 0, 32'((n_strobe - s0) + (n_err - e0)), 32'd0);

        // Inter-byte timeout
        v0 = n_valid;
        send_good(8'hA5); send_good(8'h12);
        idle(25 * BIT_CLKS);
        send_good(8'h34);
        idle(40);
        check("timeout_no_valid", n_valid - v0 == 0, 32'(n_valid - v0), 32'd0);
        check("timeout_freq_kept", freq_word == 16'hABCD, {16'h0, freq_word}, 32'hABCD);
        drained("timeout");

        // Back-to-back frames, and HDR accepted as the high byte
        v0 = n_valid;
        exp_freq.push_back(16'h1122); exp_freq.push_back(16'h3344); exp_freq.push_back(16'hA5A5);
        send_good(8'hA5); send_good(8'h11); send_good(8'h22);
        send_good(8'hA5); send_good(8'h33); send_good(8'h44);
        send_good(8'hA5); send_good(8'hA5); send_good(8'hA5);
        idle(40);
        check("b2b_three_valids", n_valid - v0 == 3, 32'(n_valid - v0), 32'd3);
        check("b2b_final_freq", freq_word == 16'hA5A5, {16'h0, freq_word}, 32'hA5A5);
        drained("b2b");

`ifdef UART_PARITY_EN
        e0 = n_err; s0 = n_strobe;
        send_good(8'hA5);
        exp_errs++;
        send_byte(8'h12, 1'b1, 1'b1);
        idle(40);
        check("parity_good_strobe", n_strobe - s0 == 1, 32'(n_strobe - s0), 32'd1);
        check("parity_bad_err", n_err - e0 == 1, 32'(n_err - e0), 32'd1);
        drained("parity");
`endif

        // Reset in the middle of a frame
        send_good(8'hA5); send_good(8'h12);
        bit_period(1'b0); bit_period(1'b1); bit_period(1'b0);
        rst_n = 1'b0;
        idle(2);
        uart_rxd = 1'b1;
        check("midrst_freq_word", freq_word == 16'h0100, {16'h0, freq_word}, 32'h0100);
        check("midrst_busy", busy == 1'b0, {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        idle(5);
        exp_freq.push_back(16'h5678);
        send_good(8'hA5); send_good(8'h56); send_good(8'h78);
        idle(40);
        check("midrst_new_frame", freq_word == 16'h5678, {16'h0, freq_word}, 32'h5678);
        drained("final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
